echo_seq_ctrl: RTL and testbench

//  Sequencer for the echo vector accelerator. On a start command it reads vregs SRC_BASE..SRC_BASE+NREGS-1

---
 rtl/echo_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_echo_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : echo_seq_ctrl
//  Purpose  : Sequencer for the echo vector accelerator. Reads NREGS source
//             vregs into a buffer, presents it to the accelerator, captures
//             the result and writes it back to NREGS destination vregs, one
//             accepted write per cycle.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start_valid/ready   - transfer request handshake (ready in IDLE)
//             busy, done          - activity flag, one-cycle completion pulse
//             rd_en/addr/data     - vreg read port (data 1 cycle after rd_en)
//             acc_src, acc_start  - source buffer and fire pulse to accelerator
//             acc_done/result     - accelerator completion and result
//             wr_en/addr/data     - vreg write port, accepted with wr_ready
//  Revision : 1.0 - initial release
// ============================================================================
module echo_seq_ctrl #(
  parameter int VREG_W   = 512,
  parameter int NREGS    = 16,
  parameter int AW       = 5,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  input  logic [VREG_W-1:0]       rd_data,
  output logic [NREGS*VREG_W-1:0] acc_src,
  output logic                    acc_start,
  input  logic                    acc_done,
  input  logic [NREGS*VREG_W-1:0] acc_result,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [VREG_W-1:0]       wr_data,
  input  logic                    wr_ready
);

  localparam int               c_iw       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [c_iw-1:0]  c_last_idx = c_iw'(NREGS - 1);
  localparam logic [AW-1:0]    c_src_base = AW'(SRC_BASE);
  localparam logic [AW-1:0]    c_dst_base = AW'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_ACC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [c_iw-1:0]                r_rd_idx;
  logic [c_iw-1:0]                r_wr_idx;
  logic [NREGS-1:0][VREG_W-1:0]   r_src_buf;
  logic [NREGS-1:0][VREG_W-1:0]   r_dst_buf;
  // Set for exactly the first ACC cycle: the only way into ACC is from DRAIN.
  logic                           r_acc_first;

  assign acc_src = r_src_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    acc_start   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) w_next = S_READ;
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = c_src_base + AW'(r_rd_idx);
        if (r_rd_idx == c_last_idx) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = S_ACC;
      end
      S_ACC: begin
        acc_start = r_acc_first;
        if (acc_done) w_next = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = c_dst_base + AW'(r_wr_idx);
        wr_data = r_dst_buf[r_wr_idx];
        if (wr_ready && (r_wr_idx == c_last_idx)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
      r_src_buf   <= '0;
      r_dst_buf   <= '0;
      r_acc_first <= 1'b0;
    end else begin
      r_acc_first <= (r_state == S_DRAIN);
      case (r_state)
        S_IDLE: begin
          r_rd_idx <= '0;
          r_wr_idx <= '0;
        end
        S_READ: begin
          r_rd_idx <= r_rd_idx + c_iw'(1);
          // Read data lags the request by one cycle, so this cycle's data
          // belongs to the previously issued index.
          if (r_rd_idx != '0) r_src_buf[r_rd_idx - c_iw'(1)] <= rd_data;
        end
        S_DRAIN: begin
          r_src_buf[c_last_idx] <= rd_data;
        end
        S_ACC: begin
          if (acc_done) begin
            r_dst_buf <= acc_result;
            r_wr_idx  <= '0;
          end
        end
        S_WRITE: begin
          if (wr_ready) r_wr_idx <= r_wr_idx + c_iw'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_echo_seq_ctrl
//  Purpose  : Scoreboard bench for echo_seq_ctrl. The stimulus process plans
//             each transfer from the sequencing rules (cycle of every read,
//             acc_start, write acceptance and done) and queues the expected
//             events; an independent monitor compares the DUT cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_echo_seq_ctrl;

  localparam int W   = 512;
  localparam int N   = 16;
  localparam int AW  = 5;
  localparam int SRC = 0;
  localparam int DST = 16;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;
  logic [N*W-1:0]   acc_src;
  logic             acc_start;
  logic             acc_done;
  logic [N*W-1:0]   acc_result;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic             wr_ready;

  echo_seq_ctrl #(
    .VREG_W(W), .NREGS(N), .AW(AW), .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .acc_src(acc_src), .acc_start(acc_start),
    .acc_done(acc_done), .acc_result(acc_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source register file contents (v0..v15); the read port returns data one
  // cycle after the request.
  logic [W-1:0] vsrc [N];
  always @(posedge clk) begin
    if (rd_en) rd_data <= vsrc[rd_addr[3:0]];
  end

  // Scoreboard queues, one entry per planned transfer (plus its writes).
  int              q_t0 [$];
  int              q_ac [$];
  int              q_ad [$];
  int              q_dn [$];
  logic [N*W-1:0]  q_src [$];
  logic [AW+W-1:0] q_wr [$];

  int n_checks = 0;
  int n_err    = 0;
  bit mon_on   = 1'b0;

  task automatic chk(input string nm, input logic [575:0] a, input logic [575:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [N*W-1:0] a, input logic [N*W-1:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d act_lo=%h exp_lo=%h", nm, cyc, a[63:0], e[63:0]);
    end
  endtask

  // ---------------- monitor ----------------
  int              m_t0, m_ac, m_ad, m_dn, m_rel;
  bit              m_busy;
  logic [AW+W-1:0] m_w;

  always @(negedge clk) begin
    if (mon_on) begin
      if (q_t0.size() > 0) begin
        m_t0   = q_t0[0];
        m_ac   = q_ac[0];
        m_ad   = q_ad[0];
        m_dn   = q_dn[0];
        m_rel  = cyc - m_t0;
        m_busy = (m_rel >= 1) && (cyc <= m_dn);
        chk("busy_ready", 576'({busy, start_ready}), 576'({m_busy, !m_busy}));
        if (m_rel >= 1 && m_rel <= N)
          chk("rd_seq", 576'({rd_en, wr_en, rd_addr}), 576'({1'b1, 1'b0, 5'(SRC + m_rel - 1)}));
        else if (rd_en)
          chk("rd_stray", 576'(rd_en), 576'(0));
        if (cyc == m_ac || acc_start)
          chk("acc_start", 576'(acc_start), 576'(cyc == m_ac));
        if (cyc >= m_ac && cyc <= m_ad)
          chk_wide("acc_src_stable", acc_src, q_src[0]);
        if (cyc == m_dn || done)
          chk("done", 576'(done), 576'(cyc == m_dn));
      end else begin
        chk("idle_outputs",
            576'({busy, done, rd_en, wr_en, acc_start, start_ready, rd_addr, wr_addr}),
            576'({5'b0, 1'b1, 10'b0}));
      end

      if (wr_en && wr_ready) begin
        if (q_wr.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL wr_unexpected cyc=%0d act_addr=%0d exp=none", cyc, wr_addr);
        end else begin
          m_w = q_wr.pop_front();
          chk("wr", 576'({wr_addr, wr_data}), 576'(m_w));
        end
      end

      if (rst) begin
        chk("wr_count_at_rst", 576'(q_wr.size()), 576'(0));
        q_t0.delete(); q_ac.delete(); q_ad.delete(); q_dn.delete();
        q_src.delete(); q_wr.delete();
      end else if (q_t0.size() > 0 && cyc == q_dn[0]) begin
        chk("wr_count", 576'(q_wr.size()), 576'(0));
        void'(q_t0.pop_front()); void'(q_ac.pop_front());
        void'(q_ad.pop_front()); void'(q_dn.pop_front());
        void'(q_src.pop_front());
      end
    end
  end

  // ---------------- stimulus + reference plan ----------------
  // Called at a cycle where the DUT is idle; that cycle becomes the accept
  // cycle t0. mode: 0 result=src, 1 result=~src, 2 result=src^random.
  task automatic run_txn(input int d, input int mode, input bit garbage, input bit hold,
                         input bit rnd_stall, input logic [63:0] stall_mask,
                         input int rst_at, input bit pat);
    logic [W-1:0]   res [N];
    logic [N*W-1:0] src_flat, res_flat;
    logic [15:0]    p16;
    bit             rdy [512];
    int             t0, ac, ad, dn, nacc, last;

    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      if (pat) begin
        p16     = 16'(i * 16'h0101);
        vsrc[i] = {32{p16}};
      end else begin
        for (int k = 0; k < W / 32; k++) vsrc[i][k*32 +: 32] = $urandom;
      end
      case (mode)
        1:       res[i] = ~vsrc[i];
        2: begin
          res[i] = vsrc[i];
          for (int k = 0; k < W / 32; k++) res[i][k*32 +: 32] ^= $urandom;
        end
        default: res[i] = vsrc[i];
      endcase
      src_flat[i*W +: W] = vsrc[i];
      res_flat[i*W +: W] = res[i];
    end

    for (int c = 0; c < 512; c++)
      rdy[c] = (c >= 400) || !((c < 64 && stall_mask[c]) ||
                               (rnd_stall && $urandom_range(3) == 0));
    if (rst_at >= 0) rdy[rst_at] = 1'b0;

    // 16 reads (cycles 1..16), drain (17), first ACC cycle at 18, d extra
    // ACC cycles, then one write per ready cycle, done the cycle after the
    // last accepted write.
    ac   = t0 + N + 2;
    ad   = ac + d;
    nacc = 0;
    dn   = 0;
    for (int c = ad - t0 + 1; c < 512 && nacc < N; c++) begin
      if (rdy[c]) begin
        if (rst_at < 0 || c < rst_at) q_wr.push_back({5'(DST + nacc), res[nacc]});
        nacc++;
        if (nacc == N) dn = t0 + c + 1;
      end
    end
    q_t0.push_back(t0);
    q_ac.push_back(ac);
    q_ad.push_back(ad);
    q_dn.push_back(dn);
    q_src.push_back(src_flat);

    last = (rst_at >= 0) ? rst_at : dn - t0;
    for (int c = 0; c <= last; c++) begin
      start_valid = (c == 0) || hold;
      rst         = (c == rst_at);
      if (c == ad - t0)                      acc_done = 1'b1;
      else if (c >= ac - t0 && c < ad - t0)  acc_done = 1'b0;
      else                                   acc_done = garbage ? 1'($urandom_range(1)) : 1'b1;
      acc_result = res_flat;
      if (c != ad - t0) acc_result[31:0] = acc_result[31:0] ^ ($urandom | 32'd1);
      wr_ready = rdy[c];
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    start_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    acc_done    = 1'b0;
    acc_result  = '0;
    wr_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;
    idle(2);

    // Baseline: patterned sources, result echoes source, no stalls (done at 35).
    run_txn(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, -1, 1'b1);
    idle(2);
    // Write stalls on cycles 22 and 25-27 (done at 39).
    run_txn(0, 0, 1'b0, 1'b0, 1'b0, 64'h0E40_0000, -1, 1'b1);
    idle(1);
    // acc_done 10 cycles after acc_start (done at 45).
    run_txn(10, 0, 1'b0, 1'b0, 1'b0, 64'h0, -1, 1'b0);
    idle(3);
    // start_valid held high: back-to-back transfers.
    run_txn(0, 2, 1'b0, 1'b1, 1'b0, 64'h0, -1, 1'b0);
    run_txn(2, 0, 1'b0, 1'b0, 1'b0, 64'h0, -1, 1'b0);
    idle(2);
    // Reset mid-READ, then reset during WRITE at wr_idx=5.
    run_txn(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 10, 1'b0);
    idle(2);
    run_txn(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 24, 1'b0);
    idle(2);
    // Garbage acc_done outside ACC, inverted result.
    run_txn(3, 1, 1'b1, 1'b0, 1'b0, 64'h0, -1, 1'b0);
    idle(2);
    // Randomised transfers.
    for (int t = 0; t < 8; t++) begin
      run_txn($urandom_range(6), $urandom_range(2), 1'($urandom_range(1)), 1'b0,
              1'b1, 64'h0, -1, 1'b0);
      idle($urandom_range(3));
    end
    idle(5);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
